bcd_seg7_converter: RTL
=======================

# bcd_seg7_converter

Sequential, parametrised binary-to-decimal display driver. Accepts a WIDTH-bit value (two's complement or unsigned), converts it to BCD with an iterative shift-and-add-3 (double-dabble) engine, and drives DIGITS seven-segment digit outputs plus a negative-sign segment. It sits between the datapath result registers and the board's HEX displays. It is the multi-digit, signed, handshaked generalisation of the team's fixed three-digit display block.

## Interface
- WIDTH, 8: input value width, 2..16.
- DIGITS, 3: number of displayed decimal digits, 1..6.
- SIGNED, 1: 1 = val is two's complement; 0 = unsigned, sign segment never lit.
- BLANK_LZ, 1: 1 = blank leading zeros (digit 0 always shown); 0 = show all digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request conversion of val; sampled only in IDLE.
- val  in  WIDTH  value to convert; sampled on the accepting edge only.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; display outputs updated this cycle.
- overflow  out  1  registered; magnitude exceeded 10^DIGITS-1 on last conversion.
- seg7_neg_sign  out  7  sign segment pattern, from seven_segment_negative.
- seg7_digits  out  7*DIGITS  digit patterns; [6:0] = ones, [13:7] = tens, etc.; each from seven_segment or blank.

## Operation
- Segment encoding is active-low. Blank digit = 7'h7F.
- FSM has two states: IDLE and CONV.
- IDLE, start=1 on an edge:
  - Latch mag = |val|. When SIGNED and val[WIDTH-1]=1, mag = two's complement negation computed in WIDTH bits. -2^(WIDTH-1) yields 2^(WIDTH-1) correctly as unsigned.
  - Latch neg_pend = SIGNED & val[WIDTH-1].
  - Clear internal BCD accumulator. It holds NB = WIDTH/3+1 digits, enough for any WIDTH-bit magnitude.
  - Load bit counter = WIDTH. Go to CONV.
- CONV, each edge:
  - Add 3 to every BCD nibble ≥5.
  - Shift {bcd, mag} left by one. Decrement counter.
- Edge that performs the final (WIDTH-th) shift:
  - Load display registers from the post-shift BCD. Assert done next cycle. Return to IDLE.
  - overflow = any BCD nibble at index ≥ DIGITS is nonzero.
  - On overflow, every displayed digit shows 9; sign still reflects neg_pend.
  - neg register = neg_pend & (magnitude ≠ 0).
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k>0 is blank if it and all higher displayed digits are 0.
  - Never blank under overflow.
- Display registers hold their value between conversions. val changes outside the accepting edge have no effect.
- start while busy is ignored; no queuing.

## Timing
- Accept edge E0. Shifts on E1..E_WIDTH. Outputs and done valid in the cycle after E_WIDTH. Latency = WIDTH+1 cycles from accept edge to done.
- busy = 1 from after E0 through the cycle ending at E_WIDTH. busy = 0 in the done cycle.
- done is high exactly one cycle. start=1 in the done cycle is accepted (back-to-back, throughput WIDTH+1 cycles).
- Reset (rst=0 on an edge) values:
  - FSM IDLE; busy=0, done=0, overflow=0, neg=0.
  - Internal value 0. Digit 0 shows "0". Other digits blank if BLANK_LZ=1, else "0".
  - seg7_neg_sign shows sign off.
- Reset mid-CONV aborts with no done pulse; display takes the reset values.
- Reset has priority over start.
- All outputs are registered or decoded directly from registers. No combinational path from val or start to any output.

## Test plan
- WIDTH=8, SIGNED=1, BLANK_LZ=1; val=8'h7F, start pulse → done exactly 9 cycles after accept edge; digits "1","2","7"; sign off; overflow=0.
- val=8'h80 → "1","2","8", sign on. val=8'hFF → ones "1", tens and hundreds blank, sign on. val=8'h00 → "0", others blank, sign off.
- SIGNED=0, val=8'hFF → "2","5","5", sign off. BLANK_LZ=0, val=8'd5 → "0","0","5".
- DIGITS=2, SIGNED=0, val=8'd100 → overflow=1, both digits "9". Next conversion of val=8'd42 → overflow=0, "4","2".
- Assert start again at E2 of a conversion with a different val → ignored; original result shown; single done. Start held high through the done cycle → second conversion begins with no idle gap.
- Drive rst=0 at E4 of a conversion → no done; busy=0 next cycle; display reset pattern. Conversion after rst=1 completes normally.

Source files
------------

// File: rtl/bcd_seg7_converter.sv
// -----------------------------------------------------------------------------
// bcd_seg7_converter
//
// Sequential binary-to-decimal display driver. A WIDTH-bit value (signed or
// unsigned) is converted to BCD with an iterative shift-and-add-3
// (double-dabble) engine, one bit per clock, and the result is shown on DIGITS
// active-low seven-segment digits plus a separate minus-sign segment.
//
// Parameters
//   WIDTH    : input value width, 2..16
//   DIGITS   : displayed decimal digits, 1..6
//   SIGNED   : 1 = val is two's complement, 0 = unsigned (sign never lit)
//   BLANK_LZ : 1 = blank leading zeros (digit 0 always shown)
//
// Ports
//   clk           : system clock, rising edge
//   rst           : synchronous active-low reset
//   start         : conversion request, only looked at while idle
//   val           : value to convert, captured on the accepting edge only
//   busy          : conversion in progress
//   done          : one-cycle pulse, display outputs updated this cycle
//   overflow      : last magnitude did not fit in DIGITS decimal digits
//   seg7_neg_sign : minus-sign segment pattern
//   seg7_digits   : digit patterns, [6:0] = ones, [13:7] = tens, ...
// -----------------------------------------------------------------------------
module bcd_seg7_converter #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SIGNED   = 1,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      val,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [6:0]            seg7_neg_sign,
    output logic [7*DIGITS-1:0]   seg7_digits
);

    // Internal BCD digits: enough for any WIDTH-bit magnitude.
    localparam int NB    = WIDTH / 3 + 1;
    // Working width that covers both the BCD digits and the displayed digits.
    localparam int EXT   = (NB > DIGITS) ? NB : DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SIGN_ON   = 7'h3F;   // only segment g lit
    localparam logic [6:0] SIGN_OFF  = 7'h7F;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Active-low digit decoder, bit0 = a ... bit6 = g. Non-decimal codes blank.
    function automatic logic [6:0] seven_segment(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Minus-sign segment pattern.
    function automatic logic [6:0] seven_segment_negative(input logic neg);
        logic [6:0] s;
        if (neg) begin
            s = SIGN_ON;
        end else begin
            s = SIGN_OFF;
        end
        return s;
    endfunction

    // Display pattern for a value of zero: "0" in digit 0, others blank or "0".
    function automatic logic [7*DIGITS-1:0] reset_digits();
        logic [7*DIGITS-1:0] r;
        r = {(7*DIGITS){1'b0}};
        for (int k = 0; k < DIGITS; k++) begin
            if (k == 0 || BLANK_LZ == 0) begin
                r[7*k +: 7] = seven_segment(4'd0);
            end else begin
                r[7*k +: 7] = SEG_BLANK;
            end
        end
        return r;
    endfunction

    localparam logic [7*DIGITS-1:0] RST_DIGITS = reset_digits();

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [WIDTH-1:0]    mag_r;
    logic [4*NB-1:0]     bcd_r;
    logic                neg_pend_r;
    logic                busy_r;
    logic                done_r;
    logic                ovf_r;
    logic [6:0]          neg_sign_r;
    logic [7*DIGITS-1:0] digits_r;

    logic                accept_s;
    logic                last_s;
    logic [WIDTH-1:0]    mag_in_s;
    logic                neg_in_s;
    logic [4*NB-1:0]     bcd_adj_s;
    logic [4*NB-1:0]     bcd_shift_s;
    logic [WIDTH-1:0]    mag_shift_s;
    logic [4*EXT-1:0]    bcd_ext_s;
    logic                ovf_s;
    logic                nz_above_s;
    logic                neg_s;
    logic [7*DIGITS-1:0] digits_s;

    // Next-state logic: accept in IDLE, leave CONV on the last shift.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = CONV;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CONV: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = IDLE;
                    last_s      = 1'b1;
                end else begin
                    state_nxt_s = CONV;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Input capture: magnitude and pending sign of the incoming value.
    always_comb begin
        neg_in_s = 1'b0;
        mag_in_s = val;
        if ((SIGNED != 0) && val[WIDTH-1]) begin
            // Negation in WIDTH bits; the most negative value wraps onto
            // 2^(WIDTH-1), which is its correct unsigned magnitude.
            neg_in_s = 1'b1;
            mag_in_s = (~val) + ONE_W;
        end else begin
            neg_in_s = 1'b0;
            mag_in_s = val;
        end
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, mag}.
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int i = 0; i < NB; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4];
            end
        end
        bcd_shift_s = {bcd_adj_s[4*NB-2:0], mag_r[WIDTH-1]};
        mag_shift_s = {mag_r[WIDTH-2:0], 1'b0};
    end

    // Display image of the post-shift BCD: overflow, sign and digit patterns.
    always_comb begin
        bcd_ext_s             = {(4*EXT){1'b0}};
        bcd_ext_s[4*NB-1:0]   = bcd_shift_s;
        // A carry out of the top nibble cannot occur for a WIDTH-bit
        // magnitude, but it would mean the value did not fit, so fold it in.
        ovf_s = bcd_adj_s[4*NB-1];
        for (int i = 0; i < EXT; i++) begin
            if (i >= DIGITS && bcd_ext_s[4*i +: 4] != 4'd0) begin
                ovf_s = 1'b1;
            end else begin
                ovf_s = ovf_s;
            end
        end
        // Walk from the most significant displayed digit down so each digit
        // knows whether anything nonzero sits at or above it.
        nz_above_s = 1'b0;
        digits_s   = {(7*DIGITS){1'b0}};
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (bcd_ext_s[4*k +: 4] != 4'd0) begin
                nz_above_s = 1'b1;
            end else begin
                nz_above_s = nz_above_s;
            end
            if (ovf_s) begin
                digits_s[7*k +: 7] = seven_segment(4'd9);
            end else if (BLANK_LZ != 0 && k > 0 && !nz_above_s) begin
                digits_s[7*k +: 7] = SEG_BLANK;
            end else begin
                digits_s[7*k +: 7] = seven_segment(bcd_ext_s[4*k +: 4]);
            end
        end
        // Minus zero is shown without a sign.
        neg_s = neg_pend_r & (bcd_shift_s != {(4*NB){1'b0}});
    end

    // State, conversion datapath and display registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            mag_r      <= {WIDTH{1'b0}};
            bcd_r      <= {(4*NB){1'b0}};
            neg_pend_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
            neg_sign_r <= SIGN_OFF;
            digits_r   <= RST_DIGITS;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == CONV);
            done_r  <= last_s;
            if (accept_s) begin
                mag_r      <= mag_in_s;
                neg_pend_r <= neg_in_s;
                bcd_r      <= {(4*NB){1'b0}};
                cnt_r      <= CNT_LOAD;
            end else if (state_r == CONV) begin
                mag_r      <= mag_shift_s;
                bcd_r      <= bcd_shift_s;
                cnt_r      <= cnt_r - CNT_ONE;
                neg_pend_r <= neg_pend_r;
            end else begin
                mag_r      <= mag_r;
                bcd_r      <= bcd_r;
                cnt_r      <= cnt_r;
                neg_pend_r <= neg_pend_r;
            end
            if (last_s) begin
                ovf_r      <= ovf_s;
                neg_sign_r <= seven_segment_negative(neg_s);
                digits_r   <= digits_s;
            end else begin
                ovf_r      <= ovf_r;
                neg_sign_r <= neg_sign_r;
                digits_r   <= digits_r;
            end
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign overflow      = ovf_r;
    assign seg7_neg_sign = neg_sign_r;
    assign seg7_digits   = digits_r;

endmodule
